fx3_bus_in_capture: RTL and testbench
=====================================

Name: fx3_bus_in_capture

Overview:
- Sits directly downstream of the FX3 inbound path controller and consumes its read-enable/data-valid stream.
- Acquires one side of a ping-pong write FIFO and sizes the packet to that side's capacity.
- Commands the inbound path controller to start a packet (enable, packet size).
- Registers FX3 data words on data-valid and writes them into the FIFO; detects short and overflowing packets.

Parameters:
- DATA_WIDTH, 32, FX3 data bus width in bits.
- MAX_PACKET, 24'd1024, upper limit on words per packet; packet size = min(i_wr_size, MAX_PACKET).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; clears all state and outputs.
- i_enable  in  1  capture enable; sampled only in IDLE.
- i_fx3_data  in  DATA_WIDTH  FX3 data bus (already synchronised to clk).
- i_data_valid  in  1  data-valid strobe from inbound path; word on i_fx3_data is valid this cycle.
- i_in_path_busy  in  1  inbound path transferring.
- i_in_path_finished  in  1  inbound path finished; stays high until o_in_path_enable drops.
- o_in_path_enable  out  1  start/hold request to inbound path.
- o_packet_size  out  24  words requested from inbound path.
- i_wr_rdy  in  2  ping-pong FIFO side free.
- o_wr_act  out  2  side currently owned (one-hot or zero).
- i_wr_size  in  24  capacity of the FIFO side in words.
- o_wr_stb  out  1  write strobe to FIFO.
- o_wr_data  out  DATA_WIDTH  write data to FIFO.
- o_word_count  out  24  words written in the current/last packet.
- o_short_packet  out  1  sticky: last packet ended with count < o_packet_size.
- o_overflow  out  1  sticky: a data-valid arrived with count == o_packet_size (word dropped).
- i_clear_status  in  1  clears o_short_packet and o_overflow (wins over same-cycle set).

Behaviour:
- Reset values: every output is 0, state = IDLE, last_side = 1.
- IDLE:
  - Wait for i_enable && (i_wr_rdy != 0) && !i_in_path_finished.
  - Side select: if both ready bits are set, take the side != last_side; otherwise take the ready side.
  - Set o_wr_act, o_packet_size = min(i_wr_size, MAX_PACKET), o_word_count = 0; go to ARM.
  - If the selected size is 0, release the side and stay in IDLE; set nothing sticky.
- ARM:
  - o_in_path_enable = 1; go to CAPTURE the next cycle.
- CAPTURE:
  - o_in_path_enable remains 1.
  - On i_data_valid with o_word_count < o_packet_size: o_wr_data <= i_fx3_data; o_wr_stb = 1 for exactly one cycle, one cycle after the valid (latency 1); o_word_count += 1.
  - On i_data_valid with o_word_count == o_packet_size: drop the word, no strobe, set o_overflow.
  - On i_in_path_finished: go to FLUSH. A valid in the same cycle is still captured.
- FLUSH (1 cycle):
  - Lets the final registered strobe issue.
  - Set o_short_packet if o_word_count < o_packet_size.
  - o_in_path_enable = 0; go to RELEASE.
- RELEASE:
  - o_wr_act = 0; last_side = released side.
  - Wait for i_in_path_finished == 0, then go to IDLE.
  - o_word_count holds until the next acquire.
- i_enable deassertion mid-packet has no effect; the packet completes. Only IDLE samples i_enable.
- i_wr_rdy changes while a side is owned are ignored.
- Back-to-back packets: IDLE to ARM with no idle gap beyond the RELEASE wait.
- Reset mid-packet: all outputs drop asynchronously. The in-path enable drop then returns the inbound path to idle.
- Counter arithmetic: 24-bit unsigned, never wraps (capped by the overflow check).

Test Plan:
- i_wr_rdy=01, i_wr_size=8, i_enable=1; 8 valids then finished -> o_wr_act=01 and o_packet_size=8; 8 strobes, each 1 cycle after its valid, data matches; o_word_count=8; no sticky bits; o_wr_act=00 after RELEASE.
- Two packets with i_wr_rdy=11 held -> first o_wr_act=01, second 10, third 01 (alternation).
- i_wr_size=4096 -> o_packet_size=1024; i_wr_size=0 -> no o_in_path_enable, side released.
- Size 4; 5 valids then finished -> 4 strobes, o_overflow=1; i_clear_status pulse -> 0.
- Size 8; 3 valids then finished -> o_short_packet=1, o_word_count=3; i_clear_status in the same cycle as the set -> stays 0.
- rst_n low after 3 of 8 words -> all outputs 0 immediately; after release, the next packet starts cleanly with o_word_count=0.

Source files
------------

// File: rtl/fx3_bus_in_capture.sv
// fx3_bus_in_capture: acquires a ping-pong FIFO side, arms the FX3 inbound path and writes captured words
module fx3_bus_in_capture #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [23:0] MAX_PACKET = 24'd1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_fx3_data,
    input  logic                  i_data_valid,
    input  logic                  i_in_path_busy,
    input  logic                  i_in_path_finished,
    output logic                  o_in_path_enable,
    output logic [23:0]           o_packet_size,
    input  logic [1:0]            i_wr_rdy,
    output logic [1:0]            o_wr_act,
    input  logic [23:0]           i_wr_size,
    output logic                  o_wr_stb,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [23:0]           o_word_count,
    output logic                  o_short_packet,
    output logic                  o_overflow,
    input  logic                  i_clear_status
);
    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, FLUSH, RELEASE} state_t;
    state_t      r_state;
    logic        r_last_side;
    logic        w_side;
    logic [23:0] w_size;
    logic        w_start;
    logic        w_unused;
    assign w_unused = i_in_path_busy;
    assign w_side   = (i_wr_rdy == 2'b11) ? ~r_last_side : i_wr_rdy[1];
    assign w_size   = (i_wr_size > MAX_PACKET) ? MAX_PACKET : i_wr_size;
    assign w_start  = i_enable && (i_wr_rdy != 2'b00) && !i_in_path_finished;
    // Packet sequencing, FIFO writes and sticky status; clear wins over a same-cycle set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_last_side      <= 1'b1;
            o_in_path_enable <= 1'b0;
            o_packet_size    <= '0;
            o_wr_act         <= '0;
            o_wr_stb         <= 1'b0;
            o_wr_data        <= '0;
            o_word_count     <= '0;
            o_short_packet   <= 1'b0;
            o_overflow       <= 1'b0;
        end else begin
            o_wr_stb <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start && w_size != 24'd0) begin
                        o_wr_act      <= w_side ? 2'b10 : 2'b01;
                        o_packet_size <= w_size;
                        o_word_count  <= '0;
                        r_state       <= ARM;
                    end
                end
                ARM: begin
                    o_in_path_enable <= 1'b1;
                    r_state          <= CAPTURE;
                end
                CAPTURE: begin
                    if (i_data_valid) begin
                        if (o_word_count < o_packet_size) begin
                            o_wr_data    <= i_fx3_data;
                            o_wr_stb     <= 1'b1;
                            o_word_count <= o_word_count + 24'd1;
                        end else begin
                            o_overflow <= 1'b1;
                        end
                    end
                    if (i_in_path_finished) r_state <= FLUSH;
                end
                FLUSH: begin
                    if (o_word_count < o_packet_size) o_short_packet <= 1'b1;
                    o_in_path_enable <= 1'b0;
                    o_wr_act         <= '0;
                    r_last_side      <= o_wr_act[1];
                    r_state          <= RELEASE;
                end
                RELEASE: begin
                    if (!i_in_path_finished) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (i_clear_status) begin
                o_short_packet <= 1'b0;
                o_overflow     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fx3_bus_in_capture.sv
// tb_fx3_bus_in_capture: scoreboard bench for the FX3 inbound capture block
module tb_fx3_bus_in_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic [31:0] i_fx3_data = '0;
    logic        i_data_valid = 1'b0;
    logic        i_in_path_busy = 1'b0;
    logic        i_in_path_finished = 1'b0;
    logic        o_in_path_enable;
    logic [23:0] o_packet_size;
    logic [1:0]  i_wr_rdy = '0;
    logic [1:0]  o_wr_act;
    logic [23:0] i_wr_size = '0;
    logic        o_wr_stb;
    logic [31:0] o_wr_data;
    logic [23:0] o_word_count;
    logic        o_short_packet;
    logic        o_overflow;
    logic        i_clear_status = 1'b0;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic m_last = 1'b1;
    logic m_short = 1'b0;
    logic m_ovf = 1'b0;

    fx3_bus_in_capture #(.DATA_WIDTH(32), .MAX_PACKET(24'd1024)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_fx3_data(i_fx3_data),
        .i_data_valid(i_data_valid), .i_in_path_busy(i_in_path_busy),
        .i_in_path_finished(i_in_path_finished), .o_in_path_enable(o_in_path_enable),
        .o_packet_size(o_packet_size), .i_wr_rdy(i_wr_rdy), .o_wr_act(o_wr_act),
        .i_wr_size(i_wr_size), .o_wr_stb(o_wr_stb), .o_wr_data(o_wr_data),
        .o_word_count(o_word_count), .o_short_packet(o_short_packet),
        .o_overflow(o_overflow), .i_clear_status(i_clear_status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && o_wr_stb) begin
            if (q.size() == 0) chk("stb_unexpected", {31'd0, o_wr_stb}, 32'd0);
            else begin
                e = q.pop_front();
                chk("wr_data", o_wr_data, e.d);
                chk("stb_latency", cyc, e.c);
            end
        end
    end

    task automatic wait_enable();
        for (int i = 0; i < 20 && !o_in_path_enable; i++) begin
            @(posedge clk); #1;
        end
        chk("in_path_enable", {31'd0, o_in_path_enable}, 32'd1);
    endtask

    task automatic run_packet(input logic [1:0] rdy, input logic [23:0] size, input int nvalid, input bit clr_flush);
        logic [23:0] psz;
        logic        side;
        int          cnt;
        psz = (size > 24'd1024) ? 24'd1024 : size;
        side = (rdy == 2'b11) ? ~m_last : rdy[1];
        i_wr_rdy = rdy;
        i_wr_size = size;
        i_enable = 1'b1;
        wait_enable();
        i_enable = 1'b0;
        chk("wr_act", {30'd0, o_wr_act}, side ? 32'd2 : 32'd1);
        chk("packet_size", {8'd0, o_packet_size}, {8'd0, psz});
        chk("word_count_start", {8'd0, o_word_count}, 32'd0);
        cnt = 0;
        for (int i = 0; i < nvalid; i++) begin
            i_data_valid = 1'b1;
            i_fx3_data = $urandom;
            if (cnt < int'(psz)) begin
                q.push_back('{d: i_fx3_data, c: cyc + 1});
                cnt++;
            end else m_ovf = 1'b1;
            @(posedge clk); #1;
        end
        i_data_valid = 1'b0;
        i_in_path_finished = 1'b1;
        @(posedge clk); #1;
        if (clr_flush) i_clear_status = 1'b1;
        @(posedge clk); #1;
        i_clear_status = 1'b0;
        if (cnt < int'(psz)) m_short = 1'b1;
        if (clr_flush) begin
            m_short = 1'b0;
            m_ovf = 1'b0;
        end
        chk("enable_released", {31'd0, o_in_path_enable}, 32'd0);
        chk("wr_act_released", {30'd0, o_wr_act}, 32'd0);
        chk("word_count_end", {8'd0, o_word_count}, cnt);
        chk("short_packet", {31'd0, o_short_packet}, {31'd0, m_short});
        chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
        m_last = side;
        i_in_path_finished = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic clear_status();
        i_clear_status = 1'b1;
        @(posedge clk); #1;
        i_clear_status = 1'b0;
        m_short = 1'b0;
        m_ovf = 1'b0;
        chk("short_cleared", {31'd0, o_short_packet}, 32'd0);
        chk("overflow_cleared", {31'd0, o_overflow}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_enable"}, {31'd0, o_in_path_enable}, 32'd0);
        chk({tag, "_psize"}, {8'd0, o_packet_size}, 32'd0);
        chk({tag, "_act"}, {30'd0, o_wr_act}, 32'd0);
        chk({tag, "_stb"}, {31'd0, o_wr_stb}, 32'd0);
        chk({tag, "_data"}, o_wr_data, 32'd0);
        chk({tag, "_count"}, {8'd0, o_word_count}, 32'd0);
        chk({tag, "_short"}, {31'd0, o_short_packet}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, o_overflow}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_packet(2'b01, 24'd8, 8, 1'b0);
        run_packet(2'b11, 24'd2, 2, 1'b0);
        run_packet(2'b11, 24'd2, 2, 1'b0);
        run_packet(2'b11, 24'd2, 2, 1'b0);
        run_packet(2'b01, 24'd4096, 2, 1'b0);
        clear_status();
        i_wr_rdy = 2'b11;
        i_wr_size = 24'd0;
        i_enable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("size0_enable", {31'd0, o_in_path_enable}, 32'd0);
            chk("size0_act", {30'd0, o_wr_act}, 32'd0);
        end
        i_enable = 1'b0;
        run_packet(2'b10, 24'd4, 5, 1'b0);
        clear_status();
        run_packet(2'b01, 24'd8, 3, 1'b1);
        i_wr_rdy = 2'b01;
        i_wr_size = 24'd8;
        i_enable = 1'b1;
        wait_enable();
        i_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_data_valid = 1'b1;
            i_fx3_data = $urandom;
            q.push_back('{d: i_fx3_data, c: cyc + 1});
            @(posedge clk); #1;
        end
        i_data_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        m_last = 1'b1;
        m_short = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_packet(2'b01, 24'd8, 8, 1'b0);
        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
